// File: rtl/rs_free_tracker.sv
// Reservation Station occupancy tracker.
// Hands the lowest free RS entry to Dispatch, one per cycle. Releases entries
// when Execute reports completion. Exports registered occupancy, full and
// empty for dispatch stall logic.
//
// Allocation handshake: alloc_req acts as valid and the internal "not full and
// not flushing" condition acts as ready. alloc_gnt = alloc_req & ready, and it
// is combinational within the same cycle. A granted entry is busy from the
// next edge. alloc_index carries meaning only while alloc_gnt=1 and is
// otherwise 0.
module rs_free_tracker #(
  parameter  int RS_ENTRIES = 16,
  localparam int IDX_W      = $clog2(RS_ENTRIES),
  localparam int CNT_W      = $clog2(RS_ENTRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  free_en,
  input  logic [IDX_W-1:0]      free_index,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [IDX_W-1:0]      alloc_index,
  input  logic                  flush,
  output logic [RS_ENTRIES-1:0] valid_vec,
  output logic [CNT_W-1:0]      occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  err_free
);

  localparam logic [RS_ENTRIES-1:0] ONE_HOT_0 = RS_ENTRIES'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(RS_ENTRIES);

  logic [IDX_W-1:0]      lowest_free;
  logic                  free_in_range;
  logic                  free_busy;
  logic                  legal_free;
  logic                  illegal_free;
  logic [RS_ENTRIES-1:0] valid_next;
  logic [CNT_W-1:0]      occ_next;
  logic                  err_next;

  // Priority encoder over the registered busy bits: the lowest clear bit wins.
  // Scanning downward lets the last match (the lowest index) take effect.
  always_comb begin
    lowest_free = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) lowest_free = IDX_W'(i);
    end
  end

  // When not full, a free entry always exists, so the encoder result is valid.
  assign alloc_gnt   = alloc_req & ~full & ~flush;
  assign alloc_index = alloc_gnt ? lowest_free : '0;

  // A free is legal only if it targets an in-range, currently busy entry.
  // Flush swallows any same-cycle free, including an illegal one.
  assign free_in_range = ({1'b0, free_index} < (IDX_W + 1)'(RS_ENTRIES));
  assign free_busy     = free_in_range && valid_vec[free_index];
  assign legal_free    = free_en & free_busy & ~flush;
  assign illegal_free  = free_en & ~free_busy & ~flush;

  // Next-state computation. A grant and a legal free never hit the same entry,
  // because a grant targets a clear bit and a free targets a set bit.
  always_comb begin
    valid_next = valid_vec;
    occ_next   = occupancy;
    err_next   = err_free | illegal_free;
    if (flush) begin
      valid_next = '0;
      occ_next   = '0;
    end else begin
      if (alloc_gnt)  valid_next = valid_next | (ONE_HOT_0 << lowest_free);
      if (legal_free) valid_next = valid_next & ~(ONE_HOT_0 << free_index);
      occ_next = occupancy + CNT_W'(alloc_gnt) - CNT_W'(legal_free);
    end
  end

  // State register. full and empty come from the next count, so they always
  // agree with valid_vec in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_vec <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err_free  <= 1'b0;
    end else begin
      valid_vec <= valid_next;
      occupancy <= occ_next;
      full      <= (occ_next == CNT_MAX);
      empty     <= (occ_next == '0);
      err_free  <= err_next;
    end
  end

endmodule

// File: tb/tb_rs_free_tracker.sv
// Bench for rs_free_tracker. The reference keeps the set of free entries as a
// queue of indices. A grant takes the smallest member of that set. A legal
// free puts its index back into the set after the clock edge.
module tb_rs_free_tracker;

  localparam int RS    = 16;
  localparam int IDX_W = $clog2(RS);
  localparam int CNT_W = $clog2(RS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             free_en;
  logic [IDX_W-1:0] free_index;
  logic             alloc_req;
  logic             alloc_gnt;
  logic [IDX_W-1:0] alloc_index;
  logic             flush;
  logic [RS-1:0]    valid_vec;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             err_free;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  int   free_q[$];
  logic m_err;

  // Values of alloc_gnt and alloc_index seen during the most recent step.
  logic last_gnt;
  int   last_idx;

  typedef struct {
    logic          fe;
    int            fi;
    logic          ar;
    logic          fl;
    logic          exp_gnt;
    int            exp_idx;
    int            exp_occ;
    logic [RS-1:0] exp_vec;
    logic          exp_err;
  } vec_t;

  vec_t tbl[11];

  rs_free_tracker #(.RS_ENTRIES(RS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .free_en     (free_en),
    .free_index  (free_index),
    .alloc_req   (alloc_req),
    .alloc_gnt   (alloc_gnt),
    .alloc_index (alloc_index),
    .flush       (flush),
    .valid_vec   (valid_vec),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .err_free    (err_free)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model helpers.
  function automatic int q_pos(input int v);
    for (int k = 0; k < free_q.size(); k++) if (free_q[k] == v) return k;
    return -1;
  endfunction

  task automatic model_clear_entries();
    free_q.delete();
    for (int i = 0; i < RS; i++) free_q.push_back(i);
  endtask

  task automatic model_grant(input logic ar, input logic fl, output logic gnt, output int idx);
    int mn;
    gnt = ar && !fl && (free_q.size() > 0);
    mn = RS;
    foreach (free_q[k]) if (free_q[k] < mn) mn = free_q[k];
    idx = gnt ? mn : 0;
  endtask

  task automatic model_update(input logic fe, input int fi, input logic fl,
                              input logic gnt, input int idx);
    logic legal;
    int   p;
    if (fl) begin
      model_clear_entries();
    end else begin
      legal = fe && (fi < RS) && (q_pos(fi) < 0);
      if (fe && !legal) m_err = 1'b1;
      if (gnt) begin
        p = q_pos(idx);
        free_q.delete(p);
      end
      if (legal) free_q.push_back(fi);
    end
  endtask

  task automatic check_regs();
    logic [RS-1:0] v;
    v = '1;
    foreach (free_q[k]) v[free_q[k]] = 1'b0;
    check("valid_vec", 32'(valid_vec), 32'(v));
    check("occupancy", 32'(occupancy), 32'(RS - free_q.size()));
    check("full",      32'(full),      32'(free_q.size() == 0));
    check("empty",     32'(empty),     32'(free_q.size() == RS));
    check("err_free",  32'(err_free),  32'(m_err));
  endtask

  // Driver: apply one cycle of inputs, check the combinational grant, clock
  // it, then check the registered state. Call at least 1 time unit after a
  // posedge so that nothing is sampled on a clock edge.
  task automatic step(input logic fe, input int fi, input logic ar, input logic fl);
    logic m_gnt;
    int   m_idx;
    free_en    = fe;
    free_index = IDX_W'(fi);
    alloc_req  = ar;
    flush      = fl;
    #1;
    model_grant(ar, fl, m_gnt, m_idx);
    last_gnt = alloc_gnt;
    last_idx = int'(alloc_index);
    check("alloc_gnt",   32'(alloc_gnt),   32'(m_gnt));
    check("alloc_index", 32'(alloc_index), 32'(m_idx));
    @(posedge clk);
    model_update(fe, fi, fl, m_gnt, m_idx);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    free_en    = 1'b0;
    free_index = '0;
    alloc_req  = 1'b0;
    flush      = 1'b0;
    model_clear_entries();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    check_regs();
    check("reset_gnt", 32'(alloc_gnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic fe, ar, fl;
    int   fi;
    int   busy[$];

    // Hand-computed sequence from reset:
    //   fe  fi  ar  fl  gnt idx occ vec      err
    tbl[0]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 1, 16'h0001, 1'b0};
    tbl[1]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 1, 2, 16'h0003, 1'b0};
    tbl[2]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 2, 3, 16'h0007, 1'b0};
    tbl[3]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 3, 4, 16'h000F, 1'b0};
    tbl[4]  = '{1'b1, 2, 1'b1, 1'b0, 1'b1, 4, 4, 16'h001B, 1'b0}; // grant + free, no bypass
    tbl[5]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 2, 5, 16'h001F, 1'b0}; // freed entry reused next cycle
    tbl[6]  = '{1'b1, 9, 1'b0, 1'b0, 1'b0, 0, 5, 16'h001F, 1'b1}; // illegal free of idle entry
    tbl[7]  = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 4, 16'h001E, 1'b1};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 0, 5, 16'h001F, 1'b1};
    tbl[9]  = '{1'b1, 3, 1'b1, 1'b1, 1'b0, 0, 0, 16'h0000, 1'b1}; // flush wins, err sticky
    tbl[10] = '{1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0, 16'h0000, 1'b1};

    do_reset();
    for (int r = 0; r < 11; r++) begin
      step(tbl[r].fe, tbl[r].fi, tbl[r].ar, tbl[r].fl);
      check($sformatf("tbl%0d_gnt", r), 32'(last_gnt),  32'(tbl[r].exp_gnt));
      check($sformatf("tbl%0d_idx", r), 32'(last_idx),  32'(tbl[r].exp_idx));
      check($sformatf("tbl%0d_occ", r), 32'(occupancy), 32'(tbl[r].exp_occ));
      check($sformatf("tbl%0d_vec", r), 32'(valid_vec), 32'(tbl[r].exp_vec));
      check($sformatf("tbl%0d_err", r), 32'(err_free),  32'(tbl[r].exp_err));
    end

    // Fill to full, stall, then free entry 5 and re-grant it.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      check($sformatf("fill_gnt%0d", c), 32'(last_gnt), 32'(c < 16));
      check($sformatf("fill_idx%0d", c), 32'(last_idx), (c < 16) ? 32'(c) : 32'd0);
    end
    check("fill_full", 32'(full),      32'd1);
    check("fill_occ",  32'(occupancy), 32'd16);
    check("fill_vec",  32'(valid_vec), 32'h0000FFFF);
    step(1'b1, 5, 1'b1, 1'b0);
    check("full_free_gnt", 32'(last_gnt),  32'd0);
    check("full_free_occ", 32'(occupancy), 32'd15);
    check("full_free_vec", 32'(valid_vec), 32'h0000FFDF);
    step(1'b0, 0, 1'b1, 1'b0);
    check("refill_idx",  32'(last_idx), 32'd5);
    check("refill_full", 32'(full),     32'd1);

    // Flush at occupancy 10 with a competing request and free.
    do_reset();
    repeat (10) step(1'b0, 0, 1'b1, 1'b0);
    check("pre_flush_occ", 32'(occupancy), 32'd10);
    step(1'b1, 3, 1'b1, 1'b1);
    check("flush_gnt",   32'(last_gnt),  32'd0);
    check("flush_occ",   32'(occupancy), 32'd0);
    check("flush_empty", 32'(empty),     32'd1);
    check("flush_err",   32'(err_free),  32'd0);

    // Asynchronous reset between edges at occupancy 7.
    do_reset();
    repeat (7) step(1'b0, 0, 1'b1, 1'b0);
    check("pre_arst_occ", 32'(occupancy), 32'd7);
    alloc_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vec",   32'(valid_vec), 32'd0);
    check("arst_occ",   32'(occupancy), 32'd0);
    check("arst_empty", 32'(empty),     32'd1);
    model_clear_entries();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model. The first phase leans
    // towards allocation to reach full often; the second leans towards frees.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      ar = ($urandom_range(0, 9) < ((c < 1000) ? 8 : 4));
      fe = ($urandom_range(0, 9) < ((c < 1000) ? 4 : 7));
      fl = ($urandom_range(0, 79) == 0);
      busy.delete();
      for (int i = 0; i < RS; i++) if (q_pos(i) < 0) busy.push_back(i);
      if (busy.size() > 0 && $urandom_range(0, 3) != 0)
        fi = busy[$urandom_range(0, busy.size() - 1)];
      else
        fi = $urandom_range(0, RS - 1);
      step(fe, fi, ar, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_free_tracker.md
Name: rs_free_tracker

Overview:
Wakeup-side tracker of Reservation Station entry occupancy. It is the receiving end of the Execute→Wakeup free channel (free_en/free_index). It allocates the lowest free RS entry to Dispatch, one per cycle. It releases entries when Execute reports instruction completion, and exports occupancy/full/empty for dispatch stall logic.

Parameters:
RS_ENTRIES, 16, number of reservation station entries (from CORE_PKG); any value ≥2, power of two not required
IDX_W, $clog2(RS_ENTRIES), entry index width (derived; not overridden)
CNT_W, $clog2(RS_ENTRIES+1), occupancy counter width (derived)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
free_en  input  1  Execute: release entry free_index this cycle
free_index  input  IDX_W  Execute: entry being released
alloc_req  input  1  Dispatch requests one RS entry this cycle
alloc_gnt  output  1  request granted this cycle (combinational)
alloc_index  output  IDX_W  granted entry; valid only when alloc_gnt=1
flush  input  1  pipeline flush: release all entries
valid_vec  output  RS_ENTRIES  registered per-entry busy bits
occupancy  output  CNT_W  registered count of busy entries
full  output  1  occupancy == RS_ENTRIES (registered)
empty  output  1  occupancy == 0 (registered)
err_free  output  1  sticky: illegal free seen (free of non-busy or out-of-range index)

Behaviour:
- Reset (async assert, sync release): valid_vec=0, occupancy=0, empty=1, full=0, err_free=0. alloc_gnt is combinational and therefore 0 whenever full or flush.
- Allocation:
  - alloc_index = lowest index i with valid_vec[i]=0, from a priority encoder over the registered valid_vec.
  - alloc_gnt = alloc_req & ~full & ~flush.
  - On a grant, valid_vec[alloc_index] sets at the next rising edge.
  - Exactly one grant per cycle.
  - When alloc_gnt=0, alloc_index is 0.
- Free:
  - free_en=1 with valid_vec[free_index]=1 and free_index<RS_ENTRIES clears that bit at the next edge.
  - No bypass: an entry freed in cycle N is first allocatable in cycle N+1.
- Illegal free (free_en=1 and either the target bit is already 0 or free_index≥RS_ENTRIES):
  - valid_vec and occupancy are unchanged.
  - err_free sets at the next edge and stays set until reset.
- Simultaneous grant and legal free: the two indices always differ, because a grant targets a non-busy entry and a free targets a busy one. Both updates apply and occupancy is unchanged.
- Occupancy next value = occupancy + grant − legal_free. It never exceeds RS_ENTRIES and never underflows. full and empty are registered from the next value, so they are exact in the same cycle as valid_vec.
- Flush:
  - Highest priority. At the next edge valid_vec=0, occupancy=0, empty=1, full=0.
  - A same-cycle free is ignored and raises no error, even if illegal.
  - err_free holds its prior value.
- Full: alloc_req is stalled (alloc_gnt=0). A legal free in a full cycle makes full=0 next cycle, and a grant is possible that cycle.
- Asynchronous reset mid-operation clears all state immediately, regardless of clk.
- Latency: grant response is 0 cycles (same cycle). State and status update 1 cycle after the grant or free.

Test Plan:
- Reset then alloc_req held high for 17 cycles (RS_ENTRIES=16) → grants with alloc_index 0,1,…,15 in cycles 1–16; cycle 17 alloc_gnt=0; full=1, occupancy=16, valid_vec=16'hFFFF.
- From full, free_en with free_index=5 → next cycle full=0, occupancy=15, valid_vec[5]=0; the following alloc_req grants alloc_index=5.
- Occupancy 4 (entries 0–3 busy): alloc_req plus free_en index 2 in the same cycle → alloc_index=4; next cycle valid_vec=4'b1011 in bits[4:0]=5'b11011, occupancy stays 4.
- free_en index 9 while valid_vec[9]=0 → valid_vec and occupancy unchanged; err_free=1 next cycle and remains 1 after a later flush; cleared only by rst_n=0.
- Occupancy 10: flush=1 together with alloc_req=1 and free_en index 3 → alloc_gnt=0 that cycle; next cycle valid_vec=0, occupancy=0, empty=1, err_free unchanged.
- Assert rst_n=0 between clock edges while occupancy=7 → valid_vec=0, occupancy=0, empty=1 immediately, without waiting for a clock edge.
